delay_tap_stage: RTL

Per-sample client of the delay-line allocator that turns one allocated buffer into a complete feedback delay effect. On each incoming audio sample it reads the buffer's delayed output, writes back the input plus scaled feedback, and emits a dry/wet mix. It sits between the upstream sample pipeline and the delay-line allocator's read/write request ports, and owns exactly one buffer handle.

---
 rtl/delay_tap_stage.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/delay_tap_stage.sv
// Feedback delay stage: one read and one write handshake with the delay-line
// allocator per input sample, then a dry/wet mix of input and delayed sample.
module delay_tap_stage #(
  parameter int data_width     = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [data_width-1:0] sample_in,
  input  logic                  sample_in_valid,
  output logic                  sample_in_ready,
  output logic [data_width-1:0] sample_out,
  output logic                  sample_out_valid,
  input  logic [data_width-1:0] cfg_handle,
  input  logic [data_width-1:0] cfg_feedback,
  input  logic [data_width-1:0] cfg_dry,
  input  logic [data_width-1:0] cfg_wet,
  input  logic [data_width-1:0] cfg_delay_inc,
  input  logic                  cfg_write,
  output logic                  read_req,
  output logic                  write_req,
  output logic [data_width-1:0] read_handle,
  output logic [data_width-1:0] write_handle,
  output logic [data_width-1:0] write_data,
  output logic [data_width-1:0] write_inc,
  input  logic [data_width-1:0] read_data,
  input  logic                  read_valid,
  input  logic                  write_ack,
  input  logic                  invalid_read,
  input  logic                  invalid_write,
  output logic                  error
);

  localparam int SW = data_width + 2;
  localparam int PW = 2 * data_width;
  localparam int CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout_cycles - 1);
  localparam logic signed [SW-1:0] MAX_S = SW'((2 ** (data_width - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_S = SW'(-(2 ** (data_width - 1)));
  localparam logic [data_width-1:0] GAIN_ONE = data_width'(16384);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, WR_WAIT, MIX, OUT
  } state_t;

  // Q2.14 product, kept at full precision until the arithmetic shift
  function automatic logic signed [SW-1:0] scale(
    input logic signed [data_width-1:0] a,
    input logic signed [data_width-1:0] g
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(g);
    return SW'(p >>> 14);
  endfunction

  function automatic logic signed [data_width-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > MAX_S) return MAX_S[data_width-1:0];
    if (v < MIN_S) return MIN_S[data_width-1:0];
    return v[data_width-1:0];
  endfunction

  state_t state_q, state_d;
  logic signed [data_width-1:0] x_q, x_d;
  logic signed [data_width-1:0] d_q, d_d;
  logic signed [data_width-1:0] y_q, y_d;
  logic                         fault_q, fault_d;
  logic                         error_q, error_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [data_width-1:0]        sample_out_q, sample_out_d;
  logic                         sample_out_valid_q, sample_out_valid_d;

  logic [data_width-1:0] sh_handle_q, sh_handle_d, act_handle_q, act_handle_d;
  logic [data_width-1:0] sh_fb_q, sh_fb_d, act_fb_q, act_fb_d;
  logic [data_width-1:0] sh_dry_q, sh_dry_d, act_dry_q, act_dry_d;
  logic [data_width-1:0] sh_wet_q, sh_wet_d, act_wet_q, act_wet_d;
  logic [data_width-1:0] sh_inc_q, sh_inc_d, act_inc_q, act_inc_d;

  logic signed [SW-1:0]         fb_term, dry_term, wet_term;
  logic signed [data_width-1:0] wdata_s, mix_s;

  always_comb begin
    fb_term  = scale(d_q, $signed(act_fb_q));
    dry_term = scale(x_q, $signed(act_dry_q));
    // A faulted sample takes the dry path only
    wet_term = fault_q ? '0 : scale(d_q, $signed(act_wet_q));
    wdata_s  = sat(SW'(x_q) + fb_term);
    mix_s    = sat(dry_term + wet_term);
  end

  // Ready stays low through the output pulse cycle
  assign sample_in_ready  = (state_q == IDLE) && !sample_out_valid_q;
  assign read_req         = enable && (state_q == RD);
  assign write_req        = enable && (state_q == WR);
  assign read_handle      = act_handle_q;
  assign write_handle     = act_handle_q;
  assign write_data       = wdata_s;
  assign write_inc        = act_inc_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign error            = error_q;

  always_comb begin
    state_d            = state_q;
    x_d                = x_q;
    d_d                = d_q;
    y_d                = y_q;
    fault_d            = fault_q;
    error_d            = error_q;
    cnt_d              = cnt_q;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    sh_handle_d        = sh_handle_q;
    sh_fb_d            = sh_fb_q;
    sh_dry_d           = sh_dry_q;
    sh_wet_d           = sh_wet_q;
    sh_inc_d           = sh_inc_q;
    act_handle_d       = act_handle_q;
    act_fb_d           = act_fb_q;
    act_dry_d          = act_dry_q;
    act_wet_d          = act_wet_q;
    act_inc_d          = act_inc_q;

    if (enable) begin
      if (cfg_write) begin
        sh_handle_d = cfg_handle;
        sh_fb_d     = cfg_feedback;
        sh_dry_d    = cfg_dry;
        sh_wet_d    = cfg_wet;
        sh_inc_d    = cfg_delay_inc;
      end

      unique case (state_q)
        IDLE: begin
          if (sample_in_valid && sample_in_ready) begin
            x_d          = $signed(sample_in);
            d_d          = '0;
            fault_d      = 1'b0;
            act_handle_d = sh_handle_q;
            act_fb_d     = sh_fb_q;
            act_dry_d    = sh_dry_q;
            act_wet_d    = sh_wet_q;
            act_inc_d    = sh_inc_q;
            state_d      = RD;
          end
        end
        RD: begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          // A response in the timeout cycle still counts as success
          if (read_valid) begin
            d_d     = $signed(read_data);
            state_d = WR;
          end else if (invalid_read || (cnt_q == CNT_LAST)) begin
            d_d     = '0;
            fault_d = 1'b1;
            error_d = 1'b1;
            state_d = MIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WR: begin
          cnt_d   = '0;
          state_d = WR_WAIT;
        end
        WR_WAIT: begin
          if (write_ack) begin
            state_d = MIX;
          end else if (invalid_write || (cnt_q == CNT_LAST)) begin
            fault_d = 1'b1;
            error_d = 1'b1;
            state_d = MIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MIX: begin
          y_d     = mix_s;
          state_d = OUT;
        end
        OUT: begin
          sample_out_d       = y_q;
          sample_out_valid_d = 1'b1;
          state_d            = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      x_q                <= '0;
      d_q                <= '0;
      y_q                <= '0;
      fault_q            <= 1'b0;
      error_q            <= 1'b0;
      cnt_q              <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      sh_handle_q        <= '0;
      sh_fb_q            <= '0;
      sh_dry_q           <= GAIN_ONE;
      sh_wet_q           <= '0;
      sh_inc_q           <= '0;
      act_handle_q       <= '0;
      act_fb_q           <= '0;
      act_dry_q          <= GAIN_ONE;
      act_wet_q          <= '0;
      act_inc_q          <= '0;
    end else begin
      state_q            <= state_d;
      x_q                <= x_d;
      d_q                <= d_d;
      y_q                <= y_d;
      fault_q            <= fault_d;
      error_q            <= error_d;
      cnt_q              <= cnt_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      sh_handle_q        <= sh_handle_d;
      sh_fb_q            <= sh_fb_d;
      sh_dry_q           <= sh_dry_d;
      sh_wet_q           <= sh_wet_d;
      sh_inc_q           <= sh_inc_d;
      act_handle_q       <= act_handle_d;
      act_fb_q           <= act_fb_d;
      act_dry_q          <= act_dry_d;
      act_wet_q          <= act_wet_d;
      act_inc_q          <= act_inc_d;
    end
  end

endmodule
